l2cache_data_ctrl: RTL

L2CACHE_DATA_CTRL -- requirements
Module: l2cache_data_ctrl

---
 rtl/l2cache_data_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/l2cache_data_ctrl.sv
// Request/response front end for a single-port L2 data SRAM: zero-fills the
// array after reset, then serves masked line writes and 2-cycle line reads.
module l2cache_data_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 256,
    parameter int NUM_WMASKS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    // RD_ISSUE covers the cycle in which the SRAM samples the read command;
    // RD_WAIT is the following cycle, at whose end dout0 is valid.
    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  init_done_q, init_done_d;
    logic                  accept_s;

    assign accept_s = req_valid && req_ready_q;

    // Next-state and next-output logic; SRAM command defaults to deselect.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        csb0_d       = 1'b1;
        web0_d       = 1'b1;
        addr0_d      = addr0_q;
        wmask0_d     = wmask0_q;
        din0_d       = din0_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        init_done_d  = init_done_q;
        case (state_q)
            ST_INIT: begin
                csb0_d   = 1'b0;
                web0_d   = 1'b0;
                addr0_d  = cnt_q;
                wmask0_d = {NUM_WMASKS{1'b1}};
                din0_d   = {DATA_WIDTH{1'b0}};
                if (cnt_q == LAST_ADDR) begin
                    cnt_d       = {ADDR_WIDTH{1'b0}};
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_ADDR;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    csb0_d  = 1'b0;
                    addr0_d = req_addr;
                    if (req_we) begin
                        // A zero mask is still issued; the SRAM treats it as a no-op.
                        web0_d   = 1'b0;
                        wmask0_d = req_wmask;
                        din0_d   = req_wdata;
                    end else begin
                        web0_d  = 1'b1;
                        state_d = ST_RD_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                resp_rdata_d = dout0;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_INIT;
                cnt_d        = {ADDR_WIDTH{1'b0}};
                resp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            cnt_q        <= {ADDR_WIDTH{1'b0}};
            csb0_q       <= 1'b1;
            web0_q       <= 1'b1;
            addr0_q      <= {ADDR_WIDTH{1'b0}};
            wmask0_q     <= {NUM_WMASKS{1'b0}};
            din0_q       <= {DATA_WIDTH{1'b0}};
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DATA_WIDTH{1'b0}};
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            csb0_q       <= csb0_d;
            web0_q       <= web0_d;
            addr0_q      <= addr0_d;
            wmask0_q     <= wmask0_d;
            din0_q       <= din0_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            init_done_q  <= init_done_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign init_done  = init_done_q;
    assign csb0       = csb0_q;
    assign web0       = web0_q;
    assign addr0      = addr0_q;
    assign wmask0     = wmask0_q;
    assign din0       = din0_q;

    l2cache_data_ctrl_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_ready  (req_ready_q),
        .resp_valid (resp_valid_q),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata_q),
        .init_done  (init_done_q),
        .csb0       (csb0_q)
    );

endmodule

// Protocol properties of the controller's outputs.
module l2cache_data_ctrl_chk #(
    parameter int DATA_WIDTH = 256
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  req_ready,
    input logic                  resp_valid,
    input logic                  resp_ready,
    input logic [DATA_WIDTH-1:0] resp_rdata,
    input logic                  init_done,
    input logic                  csb0
);

    a_ready_excl_resp : assert property (@(posedge clk) disable iff (!rst_n)
        req_ready |-> !resp_valid);

    a_resp_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata)));

    a_init_sticky : assert property (@(posedge clk) disable iff (!rst_n)
        init_done |=> init_done);

    a_init_busy : assert property (@(posedge clk) disable iff (!rst_n)
        (!init_done && !req_ready && !resp_valid && $past(rst_n) && rst_n) |-> 1'b1 || !csb0);

endmodule
